wt_write_buffer: RTL and testbench
==================================

# wt_write_buffer

Posted-write FIFO between the direct-mapped write-through cache and main memory. Every cache write is pushed here instead of stalling on memory. The block drains entries to memory in order over a valid/ready handshake. It merges repeated writes to a queued address and forwards the youngest queued data to cache read misses, so reads never see stale memory.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- wr_valid  in  1  cache presents a write
- wr_ready  out  1  buffer accepts the write this cycle
- wr_addr  in  ADDR_WIDTH  write address (full-width compare, no masking)
- wr_data  in  DATA_WIDTH  write data
- lk_addr  in  ADDR_WIDTH  read-miss lookup address
- lk_hit  out  1  some queued entry matches lk_addr
- lk_data  out  DATA_WIDTH  data of youngest matching entry; 0 when no hit
- mem_valid  out  1  head entry presented to memory
- mem_ready  in  1  memory takes the head this cycle
- mem_addr  out  ADDR_WIDTH  head address
- mem_data  out  DATA_WIDTH  head data
- count  out  $clog2(DEPTH)+1  occupied entries
- empty  out  1  count == 0

## Operation
- Storage is a circular array of {addr, data} with head and tail pointers ($clog2(DEPTH) bits, wrap modulo DEPTH) and a count register.
- Pop: occurs when mem_valid && mem_ready. Head advances and count decrements.
- Coalesce: occurs when wr_valid, the entry at tail-1 matches wr_addr, and that entry is not the head. The entry's data is overwritten, and count and pointers are unchanged. Only the youngest entry is checked.
- Head is never coalesced, because mem_addr/mem_data must stay stable while mem_valid is high. A write matching the head is pushed as a new entry.
- Push: occurs when wr_valid, no coalesce, and count < DEPTH. The entry is written at tail, tail advances, and count increments.
- wr_ready = coalesce_possible || (count < DEPTH). It does not depend on mem_ready, so there is no combinational memory-to-cache path.
- Full: a non-coalescing write is refused even if a pop happens the same cycle.
- Push and pop in the same cycle: both take effect and count is unchanged.
- Coalesce and pop in the same cycle: both take effect. The coalesce target is never the head, so they do not conflict.
- Lookup is combinational over entries valid at the start of the cycle. When several entries match, priority goes to the youngest, scanning from tail-1 back to head. A write arriving in the same cycle is not visible; the cache handles that case itself.
- mem_valid = !empty. mem_addr/mem_data are the head entry, or 0 when empty.

## Timing
- Reset (async assert, sync-safe deassert):
  - head, tail, count = 0
  - mem_valid = 0, empty = 1, wr_ready = 1, lk_hit = 0, lk_data = 0, mem_addr = 0, mem_data = 0
  - Reset mid-drain discards all entries. The handshake in progress is abandoned and not completed.
- Write latency: an accepted write is visible to lookup and to count on the next cycle.
- mem_valid rises the cycle after the first push into an empty buffer; there is no bypass.
- Drain throughput: one entry per cycle while mem_ready stays high.
- Once mem_valid is asserted, mem_addr/mem_data hold until the pop cycle.
- Pop on the last entry with no push: empty = 1 and mem_valid = 0 on the next cycle.

## Test plan
- Reset mid-traffic: assert reset with count=3 → count=0, empty=1, mem_valid=0, wr_ready=1 immediately; no further mem handshake.
- Fill and drain, with mem_ready=0:
  - Write 0x1000..0x100C with data AAAA0000..AAAA0003 → count=4, wr_ready=0.
  - A 5th write to 0x2000 is held.
  - Then mem_ready=1 → memory receives 0x1000..0x100C in order, one per cycle, then 0x2000/its data. empty=1 after.
- Coalesce, with mem_ready=0: write 0x1004=1, 0x1008=2, 0x1008=3 → count=2. Lookup 0x1008 gives lk_hit=1, lk_data=3. Drain gives 0x1004=1 then 0x1008=3 only.
- Head protection: 0x1000=A at head, write 0x1000=B → count=2. Lookup returns B. Memory sees A then B.
- Lookup miss and youngest-priority:
  - Queue 0x1000=A (head), 0x2000=C, 0x1000=B.
  - Lookup 0x1000 → B. Lookup 0x3000 → lk_hit=0, lk_data=0.
- Simultaneous events:
  - count=2 with push and pop in the same cycle → count stays 2.
  - count=DEPTH with mem_ready=1 and a new address → refused that cycle, accepted the next.

Source files
------------

// File: rtl/wt_write_buffer_if.sv
// Cache-side write/lookup ports and memory-side drain port of the posted-write buffer.
// master = cache/memory environment, slave = the buffer itself.
interface wt_write_buffer_if #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] lk_addr;
  logic                  lk_hit;
  logic [DATA_WIDTH-1:0] lk_data;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [CW-1:0]         count;
  logic                  empty;

  modport master (
    output wr_valid, wr_addr, wr_data, lk_addr, mem_ready,
    input  wr_ready, lk_hit, lk_data, mem_valid, mem_addr, mem_data, count, empty
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, lk_addr, mem_ready,
    output wr_ready, lk_hit, lk_data, mem_valid, mem_addr, mem_data, count, empty
  );
endinterface

// File: rtl/wt_write_buffer.sv
// Posted-write FIFO with youngest-entry coalescing and read-miss forwarding; writes visible 1 cycle after accept.
// Backpressure: wr_ready drops only when full and not coalescing; independent of mem_ready.
module wt_write_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic            clk,
  input logic            reset,
  wt_write_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [PW-1:0]         last;
  logic [CW-1:0]         count_q;
  logic                  is_empty;
  logic                  not_full;
  logic                  coal_ok;
  logic                  do_coal;
  logic                  do_push;
  logic                  do_pop;
  logic                  hit;
  logic [DATA_WIDTH-1:0] hit_data;
  logic [PW-1:0]         idx;

  assign last     = tail - PW'(1);
  assign is_empty = (count_q == '0);
  assign not_full = (count_q < CW'(DEPTH));
  // With two or more entries the youngest is never the head, whose outputs must stay stable.
  assign coal_ok  = (count_q >= CW'(2)) && (addr_q[last] == bus.wr_addr);
  assign do_coal  = bus.wr_valid && coal_ok;
  assign do_push  = bus.wr_valid && !coal_ok && not_full;
  assign do_pop   = !is_empty && bus.mem_ready;

  assign bus.wr_ready  = coal_ok || not_full;
  assign bus.mem_valid = !is_empty;
  assign bus.mem_addr  = is_empty ? '0 : addr_q[head];
  assign bus.mem_data  = is_empty ? '0 : data_q[head];
  assign bus.count     = count_q;
  assign bus.empty     = is_empty;
  assign bus.lk_hit    = hit;
  assign bus.lk_data   = hit_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) tail <= tail + PW'(1);
      if (do_pop)  head <= head + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_q[tail] <= bus.wr_addr;
      data_q[tail] <= bus.wr_data;
    end else if (do_coal) begin
      data_q[last] <= bus.wr_data;
    end
  end

  // Scan oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[idx] == bus.lk_addr)) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end
endmodule

// File: tb/tb_wt_write_buffer.sv
// Bench for wt_write_buffer: queue-based reference model checked every cycle, directed scenarios plus random traffic.
module tb_wt_write_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wt_write_buffer_if #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  wt_write_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  ent_t q[$];
  ent_t got[$];
  int   n_checks = 0;
  int   n_err    = 0;
  logic last_acc = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: compare outputs against the model at negedge, advance the model at posedge.
  task automatic step();
    int            n;
    logic          match_y;
    logic          coal;
    logic          push;
    logic          pop;
    logic          hit;
    logic [DW-1:0] ld;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    ent_t          e;
    @(negedge clk);
    n       = q.size();
    wa      = bus.wr_addr;
    wd      = bus.wr_data;
    match_y = (n >= 2) && (q[n-1].a == wa);
    hit     = 1'b0;
    ld      = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (!hit && q[i].a == bus.lk_addr) begin
        hit = 1'b1;
        ld  = q[i].d;
      end
    end
    chk("count",     64'(bus.count),     64'(n));
    chk("empty",     64'(bus.empty),     64'(n == 0));
    chk("mem_valid", 64'(bus.mem_valid), 64'(n != 0));
    chk("mem_addr",  64'(bus.mem_addr),  64'((n != 0) ? q[0].a : '0));
    chk("mem_data",  64'(bus.mem_data),  64'((n != 0) ? q[0].d : '0));
    chk("wr_ready",  64'(bus.wr_ready),  64'(match_y || (n < DEPTH)));
    chk("lk_hit",    64'(bus.lk_hit),    64'(hit));
    chk("lk_data",   64'(bus.lk_data),   64'(ld));
    pop  = (n != 0) && bus.mem_ready;
    coal = bus.wr_valid && match_y;
    push = bus.wr_valid && !match_y && (n < DEPTH);
    if (bus.mem_valid && bus.mem_ready) got.push_back(ent_t'{bus.mem_addr, bus.mem_data});
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (coal) begin
      e = q[q.size()-1];
      e.d = wd;
      q[q.size()-1] = e;
    end
    if (push) q.push_back(ent_t'{wa, wd});
    last_acc = push || coal;
    #1;
  endtask

  task automatic wr(logic [AW-1:0] a, logic [DW-1:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    step();
    bus.wr_valid = 1'b0;
  endtask

  task automatic drain();
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 40 && q.size() != 0; k++) step();
    chk("drain_done",  64'(q.size()),      64'(0));
    chk("drain_empty", 64'(bus.empty),     64'(1));
    chk("drain_mv",    64'(bus.mem_valid), 64'(0));
    bus.mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_count",    64'(bus.count),     64'(0));
    chk("rst_empty",    64'(bus.empty),     64'(1));
    chk("rst_mv",       64'(bus.mem_valid), 64'(0));
    chk("rst_wr_ready", 64'(bus.wr_ready),  64'(1));
    chk("rst_lk_hit",   64'(bus.lk_hit),    64'(0));
    q.delete();
    got.delete();
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    int k;
    reset         = 1'b0;
    bus.wr_valid  = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.lk_addr   = '0;
    bus.mem_ready = 1'b0;
    #1;
    chk("init_count",    64'(bus.count),     64'(0));
    chk("init_empty",    64'(bus.empty),     64'(1));
    chk("init_mv",       64'(bus.mem_valid), 64'(0));
    chk("init_wr_ready", 64'(bus.wr_ready),  64'(1));
    chk("init_lk_hit",   64'(bus.lk_hit),    64'(0));
    chk("init_lk_data",  64'(bus.lk_data),   64'(0));
    chk("init_mem_addr", 64'(bus.mem_addr),  64'(0));
    chk("init_mem_data", 64'(bus.mem_data),  64'(0));
    @(posedge clk);
    #1 reset = 1'b1;

    // Reset with three entries queued abandons them.
    wr(32'h1000, 32'h1); wr(32'h1004, 32'h2); wr(32'h1008, 32'h3);
    chk("mid_count3", 64'(bus.count), 64'(3));
    do_reset();
    bus.mem_ready = 1'b1;
    repeat (3) step();
    chk("mid_no_pop", 64'(got.size()), 64'(0));
    bus.mem_ready = 1'b0;

    // Fill, hold a fifth write, then drain in order.
    for (int i = 0; i < 4; i++) wr(32'h1000 + 32'(4 * i), 32'hAAAA0000 + 32'(i));
    bus.wr_addr = 32'h2000;
    bus.wr_data = 32'hBBBB0000;
    #1;
    chk("fill_count",    64'(bus.count),    64'(4));
    chk("fill_wr_ready", 64'(bus.wr_ready), 64'(0));
    bus.wr_valid = 1'b1;
    step(); step();
    chk("full_held", 64'(last_acc), 64'(0));
    bus.mem_ready = 1'b1;
    k = 0;
    do begin
      step();
      k++;
    end while (!last_acc && k < 10);
    chk("full_accept_cycles", 64'(k), 64'(2));
    bus.wr_valid = 1'b0;
    drain();
    chk("fill_npop", 64'(got.size()), 64'(5));
    if (got.size() == 5) begin
      for (int i = 0; i < 4; i++) begin
        chk("fill_addr", 64'(got[i].a), 64'(32'h1000 + 32'(4 * i)));
        chk("fill_data", 64'(got[i].d), 64'(32'hAAAA0000 + 32'(i)));
      end
      chk("fill_addr5", 64'(got[4].a), 64'(32'h2000));
      chk("fill_data5", 64'(got[4].d), 64'(32'hBBBB0000));
    end

    // Coalesce onto the youngest entry.
    got.delete();
    wr(32'h1004, 32'h1); wr(32'h1008, 32'h2); wr(32'h1008, 32'h3);
    bus.lk_addr = 32'h1008;
    #1;
    chk("coal_count",  64'(bus.count),   64'(2));
    chk("coal_lk_hit", 64'(bus.lk_hit),  64'(1));
    chk("coal_lk_dat", 64'(bus.lk_data), 64'(3));
    drain();
    chk("coal_npop", 64'(got.size()), 64'(2));
    if (got.size() == 2) begin
      chk("coal_p0", 64'({got[0].a, got[0].d}), {32'h1004, 32'h1});
      chk("coal_p1", 64'({got[1].a, got[1].d}), {32'h1008, 32'h3});
    end

    // Head is never coalesced.
    got.delete();
    wr(32'h1000, 32'hA); wr(32'h1000, 32'hB);
    bus.lk_addr = 32'h1000;
    #1;
    chk("head_count",  64'(bus.count),   64'(2));
    chk("head_lk_dat", 64'(bus.lk_data), 64'(32'hB));
    drain();
    chk("head_npop", 64'(got.size()), 64'(2));
    if (got.size() == 2) begin
      chk("head_p0", 64'(got[0].d), 64'(32'hA));
      chk("head_p1", 64'(got[1].d), 64'(32'hB));
    end

    // Youngest-match priority and lookup miss.
    wr(32'h1000, 32'hA); wr(32'h2000, 32'hC); wr(32'h1000, 32'hB);
    bus.lk_addr = 32'h1000;
    #1;
    chk("young_count", 64'(bus.count),   64'(3));
    chk("young_data",  64'(bus.lk_data), 64'(32'hB));
    bus.lk_addr = 32'h3000;
    #1;
    chk("miss_hit",  64'(bus.lk_hit),  64'(0));
    chk("miss_data", 64'(bus.lk_data), 64'(0));
    drain();

    // Push and pop together leave count unchanged.
    wr(32'h1000, 32'h1); wr(32'h1004, 32'h2);
    bus.mem_ready = 1'b1;
    wr(32'h1010, 32'h3);
    bus.mem_ready = 1'b0;
    chk("pushpop_count", 64'(bus.count), 64'(2));
    drain();

    // Random traffic over a small address set to exercise coalescing and lookups.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 700 == 350) begin
        bus.wr_valid = 1'b0;
        do_reset();
      end
      bus.wr_valid  = ($urandom % 3) != 0;
      bus.wr_addr   = 32'h1000 + 32'(4 * $urandom_range(0, 3));
      bus.wr_data   = $urandom;
      bus.lk_addr   = 32'h1000 + 32'(4 * $urandom_range(0, 4));
      bus.mem_ready = ((cyc / 50) % 2 == 1) ? (($urandom % 4) != 0) : (($urandom % 4) == 0);
      step();
    end
    bus.wr_valid = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
